// File: rtl/counter_rr_scheduler.sv
// Round-robin front end that shares one Counter_TOP between NUM_REQ requesters.
// One job at a time: start pulse, wait for the counter's done, then a done pulse to the owner.
module counter_rr_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int CNT_WIDTH = 7
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ*CNT_WIDTH-1:0]   cnt_val_i,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic [NUM_REQ-1:0]             done_o,
   output logic                           busy_o,
   output logic                           cnt_start_o,
   output logic [CNT_WIDTH-1:0]           cnt_val_o,
   input  logic                           cnt_done_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]           state, state_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [IDX_W-1:0]     rr_ptr, rr_ptr_n;
   logic [CNT_WIDTH-1:0] val, val_n;

   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W:0]       cand;
   logic [CNT_WIDTH-1:0] pick_val;
   logic [NUM_REQ-1:0]   owner_oh_n;

   // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first set request wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
         if (!pick_found && req_i[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      pick_val = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) pick_val = cnt_val_i[i*CNT_WIDTH +: CNT_WIDTH];
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      val_n    = val;
      rr_ptr_n = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_found) begin
               idx_n   = pick_idx;
               val_n   = pick_val;
               // A zero-length job never touches the counter.
               state_n = (pick_val != '0) ? START : DONE;
            end
         end
         START: state_n = WAIT;
         WAIT:  if (cnt_done_i) state_n = DONE;
         DONE: begin
            state_n  = IDLE;
            rr_ptr_n = (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      owner_oh_n = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         owner_oh_n[i] = (idx_n == IDX_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         val    <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         val    <= val_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   // Outputs are registered by decoding the next state, so they line up with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_o     <= '0;
         done_o      <= '0;
         busy_o      <= 1'b0;
         cnt_start_o <= 1'b0;
         cnt_val_o   <= '0;
      end else begin
         grant_o     <= (state_n != IDLE) ? owner_oh_n : '0;
         done_o      <= (state_n == DONE) ? owner_oh_n : '0;
         busy_o      <= (state_n != IDLE);
         cnt_start_o <= (state_n == START);
         cnt_val_o   <= (state_n == START) ? val_n : '0;
      end
   end

endmodule
